pcie_lane_monitor: RTL and testbench



---
 rtl/pcie_lane_monitor_pkg.sv | 37 +++
 rtl/pcie_lane_sync_ctr.sv | 75 +++++++
 rtl/pcie_lane_monitor.sv | 201 ++++++++++++++++++++
 tb/tb_pcie_lane_monitor.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_lane_monitor_pkg.sv
// pcie_lane_monitor_pkg
// Shared definitions for the PCIe lane monitor slice.
// - link_state_t : link-presence FSM encoding (IDLE/DETECT/UP/LOST)
// - LANES_MAX    : widest lane mask the monitor supports
// - TOGGLE_CNT_W : width of the per-lane saturating toggle counter
// - DROP_COUNT_W / UP_WINDOWS_W : statistics widths, only present when
//   PCIE_LANE_MONITOR_STATS_EN is defined
// - lane_popcount : number of set bits in a lane mask
package pcie_lane_monitor_pkg;

    localparam int LANES_MAX    = 8;
    localparam int TOGGLE_CNT_W = 8;

`ifdef PCIE_LANE_MONITOR_STATS_EN
    localparam int DROP_COUNT_W = 8;
    localparam int UP_WINDOWS_W = 16;
`endif

    typedef enum logic [1:0] {
        LINK_IDLE   = 2'd0,
        LINK_DETECT = 2'd1,
        LINK_UP     = 2'd2,
        LINK_LOST   = 2'd3
    } link_state_t;

    // Popcount over the full-width mask; narrower lane counts are zero-extended
    // by the caller so the result is always correct.
    function automatic logic [3:0] lane_popcount(input logic [LANES_MAX-1:0] mask);
        logic [3:0] total;
        total = '0;
        for (int i = 0; i < LANES_MAX; i++) begin
            total = total + {3'b000, mask[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/pcie_lane_sync_ctr.sv
// pcie_lane_sync_ctr
// Per-lane front end of the lane monitor: synchronizes one differential
// lane, detects valid data transitions and counts them per sampling window.
// Ports:
//   CLK, RST_N    : clock and asynchronous active-low reset
//   rxp, rxn      : raw serial legs, asynchronous to CLK
//   window_start  : first cycle of a new window; the counter restarts here
//   clear         : synchronous restart of every flop in this lane
//   saturated     : toggle count of the current window reached MIN_TOGGLES
module pcie_lane_sync_ctr
    import pcie_lane_monitor_pkg::*;
#(
    parameter int MIN_TOGGLES = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic rxp,
    input  logic rxn,
    input  logic window_start,
    input  logic clear,
    output logic saturated
);

    localparam logic [TOGGLE_CNT_W-1:0] SAT_VALUE = TOGGLE_CNT_W'(MIN_TOGGLES);
    localparam logic [TOGGLE_CNT_W-1:0] CNT_ONE   = TOGGLE_CNT_W'(1);

    logic                    rxp_meta;
    logic                    rxp_sync;
    logic                    rxp_prev;
    logic                    rxn_meta;
    logic                    rxn_sync;
    logic                    toggle;
    logic [TOGGLE_CNT_W-1:0] toggle_cnt;

    // A transition only counts while the legs are differential; both legs at
    // the same level is electrical idle, and edges seen there are noise.
    assign toggle = (rxp_sync != rxp_prev) && (rxp_sync != rxn_sync);

    assign saturated = (toggle_cnt == SAT_VALUE);

    // Two-flop synchronizers on both legs, a third flop holding the previous
    // synchronized rxp sample, and the saturating toggle counter. On the
    // window_start cycle the closing count is still visible on 'saturated'
    // (the top samples it on this edge) while the counter restarts, already
    // crediting a toggle seen in this first cycle to the new window.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rxp_meta   <= 1'b0;
            rxp_sync   <= 1'b0;
            rxp_prev   <= 1'b0;
            rxn_meta   <= 1'b0;
            rxn_sync   <= 1'b0;
            toggle_cnt <= '0;
        end else if (clear) begin
            rxp_meta   <= 1'b0;
            rxp_sync   <= 1'b0;
            rxp_prev   <= 1'b0;
            rxn_meta   <= 1'b0;
            rxn_sync   <= 1'b0;
            toggle_cnt <= '0;
        end else begin
            rxp_meta <= rxp;
            rxp_sync <= rxp_meta;
            rxp_prev <= rxp_sync;
            rxn_meta <= rxn;
            rxn_sync <= rxn_meta;
            if (window_start) begin
                toggle_cnt <= toggle ? CNT_ONE : '0;
            end else if (toggle && (toggle_cnt != SAT_VALUE)) begin
                toggle_cnt <= toggle_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/pcie_lane_monitor.sv
// pcie_lane_monitor
// Passive observer of the PCIe serial pins. Each lane is synchronized and
// its transitions counted over a 2^WINDOW_W cycle window; lanes reaching
// MIN_TOGGLES are marked active. A link-presence FSM watches the per-window
// mask and reports link_up once the same nonzero mask has been seen for
// STABLE_WINDOWS consecutive windows. The pins are never driven.
// Ports:
//   CLK, RST_N   : clock and asynchronous active-low reset
//   rxp_in/rxn_in: serial legs per lane, asynchronous to CLK
//   clear        : synchronous restart of counters, mask and FSM
//   lane_active  : per-lane active mask, updated once per window
//   lanes_up     : popcount of lane_active
//   link_state   : 0 IDLE, 1 DETECT, 2 UP, 3 LOST
//   link_up      : high only while link_state is UP
//   state_chg    : one-cycle pulse in the cycle link_state changes
// Optional (macro PCIE_LANE_MONITOR_STATS_EN):
//   drop_count   : saturating count of UP->LOST transitions
//   up_windows   : saturating count of windows evaluated while in UP
module pcie_lane_monitor
    import pcie_lane_monitor_pkg::*;
#(
    parameter int LANES          = 8,
    parameter int WINDOW_W       = 16,
    parameter int MIN_TOGGLES    = 4,
    parameter int STABLE_WINDOWS = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [LANES-1:0] rxp_in,
    input  logic [LANES-1:0] rxn_in,
    input  logic             clear,
    output logic [LANES-1:0] lane_active,
    output logic [3:0]       lanes_up,
    output logic [1:0]       link_state,
    output logic             link_up,
`ifdef PCIE_LANE_MONITOR_STATS_EN
    output logic             state_chg,
    output logic [DROP_COUNT_W-1:0] drop_count,
    output logic [UP_WINDOWS_W-1:0] up_windows
`else
    output logic             state_chg
`endif
);

    localparam logic [WINDOW_W-1:0] WIN_ONE   = WINDOW_W'(1);
    localparam logic [7:0]          STAB_MAX  = 8'(STABLE_WINDOWS);
    localparam logic [8:0]          STAB_GOAL = 9'(STABLE_WINDOWS);

    logic [WINDOW_W-1:0]  win_cnt;
    logic                 window_end;
    logic                 window_start;
    logic [LANES-1:0]     lane_sat;
    logic [LANES-1:0]     up_mask;
    logic [LANES_MAX-1:0] mask_ext;
    logic [7:0]           stab_cnt;
    logic [8:0]           stab_next;
    logic                 stab_reached;
    link_state_t          state;

    assign window_end   = &win_cnt;
    assign stab_next    = {1'b0, stab_cnt} + 9'd1;
    assign stab_reached = (stab_next >= STAB_GOAL);
    assign mask_ext     = LANES_MAX'(lane_active);
    assign lanes_up     = lane_popcount(mask_ext);
    assign link_state   = state;

    // Free-running window counter. window_start is window_end delayed by one
    // cycle, so the mask load sees counts that include the window_end cycle.
    // Clearing window_start on clear is what stops a clear on window_end
    // from producing a mask update for the aborted window.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            win_cnt      <= '0;
            window_start <= 1'b0;
        end else if (clear) begin
            win_cnt      <= '0;
            window_start <= 1'b0;
        end else begin
            win_cnt      <= win_cnt + WIN_ONE;
            window_start <= window_end;
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            pcie_lane_sync_ctr #(
                .MIN_TOGGLES (MIN_TOGGLES)
            ) u_lane (
                .CLK          (CLK),
                .RST_N        (RST_N),
                .rxp          (rxp_in[g]),
                .rxn          (rxn_in[g]),
                .window_start (window_start),
                .clear        (clear),
                .saturated    (lane_sat[g])
            );
        end
    endgenerate

    // Mask register and link-presence FSM. Both advance only on window_start:
    // lane_sat is the freshly closed window's mask, lane_active still holds
    // the previous one, which is what DETECT compares against. link_up and
    // state_chg are registered alongside the state so they move in the same
    // cycle as link_state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lane_active <= '0;
            up_mask     <= '0;
            stab_cnt    <= '0;
            state       <= LINK_IDLE;
            link_up     <= 1'b0;
            state_chg   <= 1'b0;
        end else if (clear) begin
            lane_active <= '0;
            up_mask     <= '0;
            stab_cnt    <= '0;
            state       <= LINK_IDLE;
            link_up     <= 1'b0;
            state_chg   <= 1'b0;
        end else begin
            state_chg <= 1'b0;
            if (window_start) begin
                lane_active <= lane_sat;
                case (state)
                    LINK_IDLE: begin
                        if (|lane_sat) begin
                            state     <= LINK_DETECT;
                            state_chg <= 1'b1;
                            stab_cnt  <= 8'd1;
                        end
                    end
                    LINK_DETECT: begin
                        if (lane_sat == '0) begin
                            state     <= LINK_IDLE;
                            state_chg <= 1'b1;
                            stab_cnt  <= '0;
                        end else if (lane_sat == lane_active) begin
                            if (stab_reached) begin
                                state     <= LINK_UP;
                                state_chg <= 1'b1;
                                link_up   <= 1'b1;
                                up_mask   <= lane_sat;
                                stab_cnt  <= STAB_MAX;
                            end else begin
                                stab_cnt <= stab_next[7:0];
                            end
                        end else begin
                            stab_cnt <= 8'd1;
                        end
                    end
                    LINK_UP: begin
                        if (lane_sat != up_mask) begin
                            state     <= LINK_LOST;
                            state_chg <= 1'b1;
                            link_up   <= 1'b0;
                        end
                    end
                    LINK_LOST: begin
                        state_chg <= 1'b1;
                        if (lane_sat == '0) begin
                            state    <= LINK_IDLE;
                            stab_cnt <= '0;
                        end else begin
                            state    <= LINK_DETECT;
                            stab_cnt <= 8'd1;
                        end
                    end
                    default: begin
                        state     <= LINK_IDLE;
                        state_chg <= 1'b1;
                        link_up   <= 1'b0;
                        stab_cnt  <= '0;
                    end
                endcase
            end
        end
    end

`ifdef PCIE_LANE_MONITOR_STATS_EN
    // Link statistics. Every window evaluated in UP counts as a window spent
    // in UP, including the one whose mask change drops the link to LOST.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drop_count <= '0;
            up_windows <= '0;
        end else if (clear) begin
            drop_count <= '0;
            up_windows <= '0;
        end else if (window_start && (state == LINK_UP)) begin
            if (up_windows != '1) begin
                up_windows <= up_windows + UP_WINDOWS_W'(1);
            end
            if ((lane_sat != up_mask) && (drop_count != '1)) begin
                drop_count <= drop_count + DROP_COUNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pcie_lane_monitor.sv
// tb_pcie_lane_monitor
// Window-level scoreboard bench for pcie_lane_monitor (WINDOW_W=4,
// MIN_TOGGLES=4, STABLE_WINDOWS=2). Each stimulus window places a chosen
// number of transitions per lane (optionally in electrical idle) and the
// reference model turns that into the expected mask and link state, which
// is queued and checked by an independent monitor at the mask-update cycle.
// Between updates the monitor requires all outputs to hold.
module tb_pcie_lane_monitor;

    localparam int LANES          = 8;
    localparam int WINDOW_W       = 4;
    localparam int MIN_TOGGLES    = 4;
    localparam int STABLE_WINDOWS = 2;
    localparam int WIN_LEN        = 1 << WINDOW_W;
    localparam int EVAL_OFFSET    = WIN_LEN + 1;

    logic             CLK;
    logic             RST_N;
    logic             clear;
    logic [LANES-1:0] rxp_in;
    logic [LANES-1:0] rxn_in;
    logic [LANES-1:0] lane_active;
    logic [3:0]       lanes_up;
    logic [1:0]       link_state;
    logic             link_up;
    logic             state_chg;
`ifdef PCIE_LANE_MONITOR_STATS_EN
    logic [7:0]       drop_count;
    logic [15:0]      up_windows;
`endif

    typedef struct {
        logic [7:0]  mask;
        logic [3:0]  up;
        logic [1:0]  st;
        logic        lu;
        logic        chg;
        logic [7:0]  drops;
        logic [15:0] upw;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   mcyc;
    int   tests_run;
    int   tests_failed;

    int         m_state;
    logic [7:0] m_prev;
    logic [7:0] m_upmask;
    int         m_stab;
    int         m_drops;
    int         m_upw;

    logic [7:0][2:0] pat_cnt;
    logic [7:0]      pat_idle;

    pcie_lane_monitor #(
        .LANES          (LANES),
        .WINDOW_W       (WINDOW_W),
        .MIN_TOGGLES    (MIN_TOGGLES),
        .STABLE_WINDOWS (STABLE_WINDOWS)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .rxp_in      (rxp_in),
        .rxn_in      (rxn_in),
        .clear       (clear),
        .lane_active (lane_active),
        .lanes_up    (lanes_up),
        .link_state  (link_state),
        .link_up     (link_up),
`ifdef PCIE_LANE_MONITOR_STATS_EN
        .state_chg   (state_chg),
        .drop_count  (drop_count),
        .up_windows  (up_windows)
`else
        .state_chg   (state_chg)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [15:0] dutOutputs();
        return {lane_active, lanes_up, link_state, link_up, state_chg};
    endfunction

    task automatic modelReset();
        m_state  = 0;
        m_prev   = '0;
        m_upmask = '0;
        m_stab   = 0;
        m_drops  = 0;
        m_upw    = 0;
    endtask

    // Reference link model: one call per completed window, working directly
    // from the window's lane mask with the link-presence rules.
    task automatic modelEval(input logic [7:0] mask, output exp_t e);
        int old_state;
        old_state = m_state;
        case (m_state)
            0: begin
                if (mask != 0) begin
                    m_state = 1;
                    m_stab  = 1;
                end
            end
            1: begin
                if (mask == 0) begin
                    m_state = 0;
                end else if (mask == m_prev) begin
                    m_stab++;
                    if (m_stab >= STABLE_WINDOWS) begin
                        m_state  = 2;
                        m_upmask = mask;
                    end
                end else begin
                    m_stab = 1;
                end
            end
            2: begin
                if (m_upw < 65535) m_upw++;
                if (mask != m_upmask) begin
                    m_state = 3;
                    if (m_drops < 255) m_drops++;
                end
            end
            default: begin
                m_state = (mask == 0) ? 0 : 1;
                m_stab  = 1;
            end
        endcase
        m_prev  = mask;
        e.mask  = mask;
        e.up    = 4'($countones(mask));
        e.st    = 2'(m_state);
        e.lu    = (m_state == 2);
        e.chg   = (m_state != old_state);
        e.drops = 8'(m_drops);
        e.upw   = 16'(m_upw);
    endtask

    // Async reset asserted between clock edges, with pins wiggling while it
    // is held; pins return to zero before release so the synchronizers and
    // the pins agree when counting resumes. Returns at the negedge of the
    // first post-reset cycle.
    task automatic doReset();
        #2 RST_N = 1'b0;
        #1 checkOutput("async_reset_now", 32'(dutOutputs()), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            rxp_in = 8'($urandom);
            rxn_in = 8'($urandom);
        end
        @(negedge CLK);
        rxp_in = '0;
        rxn_in = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        modelReset();
    endtask

    // Drives one window starting at the negedge of its first cycle. Lane l
    // makes cnts[l] transitions on odd slots, far enough from the boundaries
    // that the synchronizer delay keeps them inside this window. abort=1
    // raises clear on the window_end cycle; abort=2 resets mid-window.
    task automatic applyStimulus(input logic [7:0][2:0] cnts, input logic [7:0] idle, input int abort);
        logic [7:0] flip;
        logic [7:0] mask;
        exp_t       e;
        clear = 1'b0;
        for (int s = 0; s < WIN_LEN; s++) begin
            if (s == 0) begin
                rxn_in = (rxp_in & idle) | (~rxp_in & ~idle);
            end else if ((s % 2) == 1) begin
                flip = '0;
                for (int l = 0; l < LANES; l++) begin
                    if (((s - 1) / 2) < int'(cnts[l])) flip[l] = 1'b1;
                end
                rxp_in = rxp_in ^ flip;
                rxn_in = rxn_in ^ flip;
            end
            if (abort == 2 && s == 7) begin
                doReset();
                return;
            end
            if (abort == 1 && s == WIN_LEN - 3) begin
                rxp_in = '0;
                rxn_in = '0;
            end
            if (abort == 1 && s == WIN_LEN - 1) clear = 1'b1;
            @(negedge CLK);
        end
        if (abort == 1) begin
            modelReset();
        end else begin
            for (int l = 0; l < LANES; l++) begin
                mask[l] = !idle[l] && (int'(cnts[l]) >= MIN_TOGGLES);
            end
            modelEval(mask, e);
            sb_q.push_back(e);
        end
    endtask

    // Cycle bookkeeping for the monitor: reset or a sampled clear restarts
    // the window phase and wipes the expected hold values.
    always @(posedge CLK) begin
        if (!RST_N || clear) begin
            mcyc           = 0;
            last_exp.mask  = '0;
            last_exp.up    = '0;
            last_exp.st    = '0;
            last_exp.lu    = 1'b0;
            last_exp.chg   = 1'b0;
            last_exp.drops = '0;
            last_exp.upw   = '0;
            sb_q.delete();
        end else begin
            mcyc++;
        end
    end

    // Monitor: on the mask-update cycle pop and compare the expected window
    // result; on every other cycle the outputs must hold with no state_chg.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            checkOutput("reset_outputs", 32'(dutOutputs()), 32'h0);
`ifdef PCIE_LANE_MONITOR_STATS_EN
            checkOutput("reset_stats", {8'h0, drop_count, up_windows}, 32'h0);
`endif
        end else if (mcyc >= EVAL_OFFSET && ((mcyc - EVAL_OFFSET) % WIN_LEN) == 0) begin
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL scoreboard_underflow: got no entry, expected one at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                checkOutput("lane_active", 32'(lane_active), 32'(e.mask));
                checkOutput("lanes_up", 32'(lanes_up), 32'(e.up));
                checkOutput("link_state", 32'(link_state), 32'(e.st));
                checkOutput("link_up", 32'(link_up), 32'(e.lu));
                checkOutput("state_chg", 32'(state_chg), 32'(e.chg));
`ifdef PCIE_LANE_MONITOR_STATS_EN
                checkOutput("drop_count", 32'(drop_count), 32'(e.drops));
                checkOutput("up_windows", 32'(up_windows), 32'(e.upw));
`endif
                last_exp = e;
            end
        end else begin
            checkOutput("hold_outputs", 32'(dutOutputs()),
                        32'({last_exp.mask, last_exp.up, last_exp.st, last_exp.lu, 1'b0}));
`ifdef PCIE_LANE_MONITOR_STATS_EN
            checkOutput("hold_stats", {8'h0, drop_count, up_windows},
                        {8'h0, last_exp.drops, last_exp.upw});
`endif
        end
    end

    function automatic logic [7:0][2:0] uniformCounts(input logic [7:0] lanes, input logic [2:0] n);
        logic [7:0][2:0] c;
        for (int l = 0; l < LANES; l++) c[l] = lanes[l] ? n : 3'd0;
        return c;
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        mcyc         = 0;
        RST_N        = 1'b1;
        clear        = 1'b0;
        rxp_in       = '0;
        rxn_in       = '0;
        modelReset();
        doReset();

        for (int w = 0; w < 10; w++) applyStimulus('0, 8'h00, 0);

        pat_cnt = uniformCounts(8'h0F, 3'd7);
        for (int w = 0; w < 3; w++) applyStimulus(pat_cnt, 8'h00, 0);

        for (int w = 0; w < 4; w++) applyStimulus(pat_cnt, 8'h04, 0);

        pat_cnt[0] = 3'd3;
        for (int w = 0; w < 2; w++) applyStimulus(pat_cnt, 8'h00, 0);
        pat_cnt[0] = 3'd4;
        for (int w = 0; w < 2; w++) applyStimulus(pat_cnt, 8'h00, 0);

        pat_cnt = uniformCounts(8'h07, 3'd7);
        for (int w = 0; w < 4; w++) applyStimulus(pat_cnt, 8'h00, 0);

        applyStimulus(pat_cnt, 8'h00, 0);
        applyStimulus('0, 8'h00, 0);

        pat_idle = '0;
        for (int w = 0; w < 30; w++) begin
            if (w == 0 || $urandom_range(0, 3) == 0) begin
                for (int l = 0; l < LANES; l++) begin
                    pat_cnt[l]  = 3'($urandom_range(0, 7));
                    pat_idle[l] = ($urandom_range(0, 7) == 0);
                end
                if ($urandom_range(0, 9) == 0) pat_cnt = '0;
            end
            applyStimulus(pat_cnt, pat_idle, 0);
        end

        pat_cnt = uniformCounts(8'hFF, 3'd7);
        for (int w = 0; w < 3; w++) applyStimulus(pat_cnt, 8'h00, 0);
        applyStimulus(pat_cnt, 8'h00, 1);
        for (int w = 0; w < 3; w++) applyStimulus(pat_cnt, 8'h00, 0);

        applyStimulus(pat_cnt, 8'h00, 2);
        for (int w = 0; w < 3; w++) applyStimulus(pat_cnt, 8'h00, 0);

        repeat (3) @(negedge CLK);
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
